// File: rtl/cheshire_boot_seq_pkg.sv
// Shared types and constants for the Cheshire reset/boot sequencer.
package cheshire_boot_seq_pkg;

  localparam int unsigned ExitCodeWidth = 32;
  localparam int unsigned BootModeWidth = 2;
  localparam logic [BootModeWidth-1:0] BootModePassive = 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_SETTLE,
    ST_PRELOAD,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } boot_seq_state_e;

endpackage

// File: rtl/cheshire_boot_seq_rtc_div.sv
// Free-running divider: rtc_o toggles every Div clock cycles.
module cheshire_boot_seq_rtc_div #(
  parameter int unsigned Div = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rtc_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      rtc_o <= 1'b0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
      rtc_o <= ~rtc_o;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/cheshire_boot_seq.sv
// Reset/boot sequencer: SoC reset, mode latching, preload handshake, exit capture and watchdog.
module cheshire_boot_seq
  import cheshire_boot_seq_pkg::*;
#(
  parameter int unsigned RstCycles     = 16,
  parameter int unsigned SettleCycles  = 8,
  parameter int unsigned RtcDiv        = 4,
  parameter int unsigned TimeoutCycles = 1000000,
  parameter int unsigned CntWidth      = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [BootModeWidth-1:0] boot_mode_i,
  input  logic                     test_mode_i,
  output logic                     soc_rst_no,
  output logic [BootModeWidth-1:0] soc_boot_mode_o,
  output logic                     soc_test_mode_o,
  output logic                     rtc_o,
  output logic                     preload_req_o,
  input  logic                     preload_ack_i,
  input  logic                     exit_valid_i,
  input  logic [ExitCodeWidth-1:0] exit_code_i,
  output logic [ExitCodeWidth-1:0] exit_code_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     timeout_o
);

  localparam logic [CntWidth-1:0] RstLast    = CntWidth'(RstCycles - 1);
  localparam logic [CntWidth-1:0] SettleLast = CntWidth'(SettleCycles - 1);
  localparam logic [CntWidth-1:0] WdogLast   =
    CntWidth'((TimeoutCycles == 0) ? 32'd0 : TimeoutCycles - 1);
  localparam bit WdogEn = (TimeoutCycles != 0);

  boot_seq_state_e state_q, state_d;
  logic [CntWidth-1:0]      phase_q, phase_d, wdog_q, wdog_d;
  logic                     soc_rst_d, test_mode_d, preload_req_d;
  logic                     busy_d, done_d, timeout_d;
  logic [BootModeWidth-1:0] boot_mode_d;
  logic [ExitCodeWidth-1:0] exit_code_d;
  logic                     wdog_expired;
  logic [CntWidth-1:0]      wdog_inc;

  assign wdog_expired = WdogEn && (wdog_q >= WdogLast);
  assign wdog_inc     = (wdog_q == '1) ? wdog_q : wdog_q + CntWidth'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      phase_q         <= '0;
      wdog_q          <= '0;
      soc_rst_no      <= 1'b0;
      soc_boot_mode_o <= '0;
      soc_test_mode_o <= 1'b0;
      preload_req_o   <= 1'b0;
      exit_code_o     <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      timeout_o       <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      wdog_q          <= wdog_d;
      soc_rst_no      <= soc_rst_d;
      soc_boot_mode_o <= boot_mode_d;
      soc_test_mode_o <= test_mode_d;
      preload_req_o   <= preload_req_d;
      exit_code_o     <= exit_code_d;
      busy_o          <= busy_d;
      done_o          <= done_d;
      timeout_o       <= timeout_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    wdog_d        = wdog_q;
    soc_rst_d     = soc_rst_no;
    boot_mode_d   = soc_boot_mode_o;
    test_mode_d   = soc_test_mode_o;
    preload_req_d = preload_req_o;
    exit_code_d   = exit_code_o;
    busy_d        = busy_o;
    done_d        = done_o;
    timeout_d     = timeout_o;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start_i) begin
          state_d       = ST_RESET;
          phase_d       = '0;
          boot_mode_d   = boot_mode_i;
          test_mode_d   = test_mode_i;
          soc_rst_d     = 1'b0;
          preload_req_d = 1'b0;
          exit_code_d   = '0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      ST_RESET: begin
        if (phase_q == RstLast) begin
          state_d   = ST_SETTLE;
          phase_d   = '0;
          soc_rst_d = 1'b1;
        end else begin
          phase_d = phase_q + CntWidth'(1);
        end
      end
      ST_SETTLE: begin
        if (phase_q == SettleLast) begin
          wdog_d = '0;
          if (soc_boot_mode_o == BootModePassive) begin
            state_d       = ST_PRELOAD;
            preload_req_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          phase_d = phase_q + CntWidth'(1);
        end
      end
      // Expiry beats a coincident ack; in RUN an exit beats expiry.
      ST_PRELOAD: begin
        wdog_d = wdog_inc;
        if (wdog_expired) begin
          state_d       = ST_TIMEOUT;
          preload_req_d = 1'b0;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          timeout_d     = 1'b1;
        end else if (preload_ack_i) begin
          state_d       = ST_RUN;
          preload_req_d = 1'b0;
        end
      end
      ST_RUN: begin
        wdog_d = wdog_inc;
        if (exit_valid_i) begin
          state_d     = ST_DONE;
          exit_code_d = exit_code_i;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else if (wdog_expired) begin
          state_d   = ST_TIMEOUT;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  cheshire_boot_seq_rtc_div #(
    .Div(RtcDiv)
  ) u_rtc_div (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .rtc_o (rtc_o)
  );

endmodule

// File: tb/tb_cheshire_boot_seq.sv
// Bench for cheshire_boot_seq: directed vector table, rtc sequence and random run against a timestamp model.
module tb_cheshire_boot_seq;

  localparam int R = 16;
  localparam int S = 8;
  localparam int D = 3;
  localparam int T = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni, start_i, test_mode_i, preload_ack_i, exit_valid_i;
  logic [1:0]  boot_mode_i;
  logic [31:0] exit_code_i;
  logic        soc_rst_no, soc_test_mode_o, rtc_o, preload_req_o;
  logic        busy_o, done_o, timeout_o;
  logic [1:0]  soc_boot_mode_o;
  logic [31:0] exit_code_o;

  cheshire_boot_seq #(
    .RstCycles(R), .SettleCycles(S), .RtcDiv(D), .TimeoutCycles(T), .CntWidth(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .boot_mode_i(boot_mode_i),
    .test_mode_i(test_mode_i), .soc_rst_no(soc_rst_no), .soc_boot_mode_o(soc_boot_mode_o),
    .soc_test_mode_o(soc_test_mode_o), .rtc_o(rtc_o), .preload_req_o(preload_req_o),
    .preload_ack_i(preload_ack_i), .exit_valid_i(exit_valid_i), .exit_code_i(exit_code_i),
    .exit_code_o(exit_code_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: sequence described by the edge of start acceptance and elapsed time.
  int          n = 0;
  int          rst_edge = 0;
  int          acc = 0;
  int          work = 0;
  bit          m_active = 0, m_fin = 0, m_tout = 0, m_ackd = 0;
  logic [1:0]  m_mode = 0;
  logic        m_tm = 0;
  logic [31:0] m_code = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, n);
    end
  endtask

  task automatic model_edge(input logic r, input logic st, input logic [1:0] md,
                            input logic tm, input logic ak, input logic ev,
                            input logic [31:0] cd);
    int  el;
    bit  expired;
    if (!r) begin
      m_active = 0; m_fin = 0; m_tout = 0; m_ackd = 0;
      m_mode = 0; m_tm = 0; m_code = 0; rst_edge = n;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1; acc = n; work = n + R + S;
        m_mode = md; m_tm = tm; m_fin = 0; m_tout = 0; m_code = 0; m_ackd = 0;
      end
    end else if (n - 1 >= work) begin
      el = n - 1 - work;
      expired = (T != 0) && (el >= T - 1);
      if (m_mode == 2'd0 && !m_ackd) begin
        if (expired) begin m_active = 0; m_fin = 1; m_tout = 1; end
        else if (ak) m_ackd = 1;
      end else begin
        if (ev) begin m_active = 0; m_fin = 1; m_code = cd; end
        else if (expired) begin m_active = 0; m_fin = 1; m_tout = 1; end
      end
    end
  endtask

  task automatic model_check();
    logic e_rstn, e_preq;
    e_rstn = m_active ? (n >= acc + R) : m_fin;
    e_preq = m_active && (n >= work) && (m_mode == 2'd0) && !m_ackd;
    chk("m_soc_rst_no", 32'(soc_rst_no), 32'(e_rstn));
    chk("m_preload_req", 32'(preload_req_o), 32'(e_preq));
    chk("m_busy", 32'(busy_o), 32'(m_active));
    chk("m_done", 32'(done_o), 32'(m_fin));
    chk("m_timeout", 32'(timeout_o), 32'(m_fin && m_tout));
    chk("m_exit_code", exit_code_o, m_code);
    chk("m_boot_mode", 32'(soc_boot_mode_o), 32'(m_mode));
    chk("m_test_mode", 32'(soc_test_mode_o), 32'(m_tm));
    chk("m_rtc", 32'(rtc_o), 32'(((n - rst_edge) / D) % 2));
  endtask

  // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
  task automatic step(input logic r, input logic st, input logic [1:0] md, input logic tm,
                      input logic ak, input logic ev, input logic [31:0] cd);
    rst_ni = r; start_i = st; boot_mode_i = md; test_mode_i = tm;
    preload_ack_i = ak; exit_valid_i = ev; exit_code_i = cd;
    @(posedge clk);
    n++;
    model_edge(r, st, md, tm, ak, ev, cd);
    #1;
    model_check();
  endtask

  typedef struct {
    int          wait_n;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic        ack;
    logic        ev;
    logic [31:0] code;
    logic        e_rstn, e_preq, e_busy, e_done, e_tout;
    logic [31:0] e_code;
  } vec_t;

  function automatic vec_t mk(int w, logic r, logic st, logic [1:0] md, logic ak, logic ev,
                              logic [31:0] cd, logic er, logic ep, logic eb, logic ed,
                              logic et, logic [31:0] ec);
    vec_t v;
    v.wait_n = w; v.rst = r; v.start = st; v.mode = md; v.ack = ak; v.ev = ev; v.code = cd;
    v.e_rstn = er; v.e_preq = ep; v.e_busy = eb; v.e_done = ed; v.e_tout = et; v.e_code = ec;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    //              wait rst st mode ack ev code        rstn preq busy done tout code
    vecs.push_back(mk( 0, 0, 0, 2'd0, 0, 0, 32'h0,       0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk( 3, 1, 1, 2'd1, 0, 0, 32'h0,       0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(14, 1, 0, 2'd0, 0, 0, 32'h0,       0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk( 0, 1, 0, 2'd0, 0, 0, 32'h0,       1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk( 7, 1, 0, 2'd0, 0, 0, 32'h0,       1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(10, 1, 0, 2'd0, 0, 1, 32'h1,       1, 0, 0, 1, 0, 32'h1));
    vecs.push_back(mk( 2, 1, 1, 2'd0, 0, 0, 32'h0,       0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(22, 1, 0, 2'd0, 0, 0, 32'h0,       1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk( 0, 1, 0, 2'd0, 0, 0, 32'h0,       1, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(14, 1, 0, 2'd0, 1, 0, 32'h0,       1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk( 5, 1, 0, 2'd0, 0, 1, 32'h3,       1, 0, 0, 1, 0, 32'h3));
    vecs.push_back(mk( 1, 1, 1, 2'd2, 0, 0, 32'h0,       0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(23, 1, 0, 2'd0, 0, 0, 32'h0,       1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(38, 1, 0, 2'd0, 0, 0, 32'h0,       1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk( 0, 1, 0, 2'd0, 0, 0, 32'h0,       1, 0, 0, 1, 1, 32'h0));
    vecs.push_back(mk( 0, 1, 1, 2'd3, 0, 0, 32'h0,       0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(23, 1, 0, 2'd0, 0, 0, 32'h0,       1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(39, 1, 0, 2'd0, 0, 1, 32'hDEADBEEF, 1, 0, 0, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk( 0, 1, 1, 2'd0, 0, 0, 32'h0,       0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(23, 1, 0, 2'd0, 0, 0, 32'h0,       1, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(39, 1, 0, 2'd0, 1, 0, 32'h0,       1, 0, 0, 1, 1, 32'h0));
    vecs.push_back(mk( 0, 1, 1, 2'd1, 0, 0, 32'h0,       0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(23, 1, 0, 2'd0, 0, 0, 32'h0,       1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk( 2, 1, 1, 2'd0, 0, 0, 32'h0,       1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk( 0, 1, 0, 2'd0, 0, 1, 32'h5,       1, 0, 0, 1, 0, 32'h5));
    vecs.push_back(mk( 0, 1, 1, 2'd0, 0, 0, 32'h0,       0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk( 5, 1, 0, 2'd0, 1, 1, 32'h9,       0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(17, 1, 0, 2'd0, 0, 0, 32'h0,       1, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk( 3, 0, 0, 2'd0, 0, 0, 32'h0,       0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk( 2, 1, 0, 2'd0, 1, 1, 32'h7,       0, 0, 0, 0, 0, 32'h0));

    rst_ni = 1'b0; start_i = 1'b0; boot_mode_i = 2'd0; test_mode_i = 1'b0;
    preload_ack_i = 1'b0; exit_valid_i = 1'b0; exit_code_i = 32'h0;
    #1;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int w = 0; w < vecs[i].wait_n; w++) step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(vecs[i].rst, vecs[i].start, vecs[i].mode, vecs[i].mode == 2'd1,
           vecs[i].ack, vecs[i].ev, vecs[i].code);
      chk($sformatf("v%0d_soc_rst_no", i), 32'(soc_rst_no), 32'(vecs[i].e_rstn));
      chk($sformatf("v%0d_preload_req", i), 32'(preload_req_o), 32'(vecs[i].e_preq));
      chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_done", i), 32'(done_o), 32'(vecs[i].e_done));
      chk($sformatf("v%0d_timeout", i), 32'(timeout_o), 32'(vecs[i].e_tout));
      chk($sformatf("v%0d_exit_code", i), exit_code_o, vecs[i].e_code);
    end

    // rtc phase after a reset, with a sequence started right away.
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, k == 1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h0);
      if (k % 3 == 0) chk($sformatf("rtc_edge%0d", k), 32'(rtc_o), 32'((k / 3) % 2));
    end

    // Random traffic, compared against the model every cycle.
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 399) != 0, $urandom_range(0, 15) == 0,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
